// File: rtl/final_soc_key_pkg.sv
// Shared constants and event type for the key controller.
// Holds register addresses, EVENT/STATUS bit positions and the event bundle.
package final_soc_key_pkg;

  localparam logic [1:0] ADDR_STATE   = 2'd0;
  localparam logic [1:0] ADDR_EVENT   = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int EV_VALID_BIT = 31;
  localparam int EV_RPT_BIT   = 9;
  localparam int EV_PRESS_BIT = 8;
  localparam int EV_IDX_LSB   = 0;

  localparam int ST_CNT_LSB   = 0;
  localparam int ST_OVF_BIT   = 16;
  localparam int ST_FLUSH_BIT = 0;

  typedef struct packed {
    logic       rpt;
    logic       press;
    logic [2:0] idx;
  } key_event_t;

  function automatic logic [31:0] ev_word(key_event_t e);
    logic [31:0] w;
    w = '0;
    w[EV_VALID_BIT] = 1'b1;
    w[EV_RPT_BIT] = e.rpt;
    w[EV_PRESS_BIT] = e.press;
    w[EV_IDX_LSB +: 3] = e.idx;
    return w;
  endfunction

endpackage

// File: rtl/final_soc_key_debounce.sv
// One key: 2-flop sync of the inverted raw level, debounce counter,
// stable state and a pending event flag (kind = press/repeat).
// Ports: clk, reset_n, raw (active-low key), clr (arbiter took the event),
//   stable, pending, press, rpt.
// Autorepeat is built only with FINAL_SOC_KEY_CTRL_AUTOREPEAT_EN.
module final_soc_key_debounce
  import final_soc_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  input  logic clr,
  output logic stable,
  output logic pending,
  output logic press,
  output logic rpt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          toggle;
  logic          rep_hit;

  assign toggle = (s2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      s1 <= ~raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (toggle) begin
        cnt    <= '0;
        stable <= ~stable;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef FINAL_SOC_KEY_CTRL_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  logic [RW-1:0] rcnt;

  assign rep_hit = stable && !toggle &&
                   (rcnt == RW'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt <= '0;
    end else if (!stable || toggle || rep_hit) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end
`else
  localparam int UNUSED_REPEAT = REPEAT_CYCLES;
  assign rep_hit = 1'b0;
`endif

  // A new event overrides a clear landing on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      press   <= 1'b0;
      rpt     <= 1'b0;
    end else if (toggle) begin
      pending <= 1'b1;
      press   <= ~stable;
      rpt     <= 1'b0;
    end else if (rep_hit) begin
      pending <= 1'b1;
      press   <= 1'b1;
      rpt     <= 1'b1;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/final_soc_key_ctrl.sv
// Debounced key-event controller: per-key debounce, priority arbiter,
// event FIFO and Avalon-MM slave (STATE, EVENT, IRQMASK, STATUS).
// Ports: clk, reset_n, address, chipselect, read, write_n, writedata,
//   readdata, in_port (active-low keys), irq.
// Option macro: FINAL_SOC_KEY_CTRL_AUTOREPEAT_EN.
module final_soc_key_ctrl
  import final_soc_key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 8,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [NUM_KEYS-1:0] in_port,
  output logic                irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] pend;
  logic [NUM_KEYS-1:0] kpress;
  logic [NUM_KEYS-1:0] krpt;
  logic [NUM_KEYS-1:0] clr;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    final_soc_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (in_port[k]),
      .clr    (clr[k]),
      .stable (stable[k]),
      .pending(pend[k]),
      .press  (kpress[k]),
      .rpt    (krpt[k])
    );
  end

  logic       push;
  key_event_t ev;

  // Scan high to low so the lowest pending index wins.
  always_comb begin
    push = 1'b0;
    ev   = '0;
    clr  = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        push     = 1'b1;
        ev.rpt   = krpt[i];
        ev.press = kpress[i];
        ev.idx   = 3'(i);
        clr      = '0;
        clr[i]   = 1'b1;
      end
    end
  end

  key_event_t    mem [FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [6:0]    count;
  logic          ovf;
  logic          mask;
  logic          full;
  logic          empty;
  logic          wr;
  logic          pop;
  logic          flush;
  logic          push_ok;
  logic [31:0]   rdata;
  logic          unused_wd;

  assign unused_wd = ^{writedata[31:17], writedata[15:1]};

  assign full    = (count == 7'(FIFO_DEPTH));
  assign empty   = (count == 7'd0);
  assign wr      = chipselect && !write_n;
  assign pop     = chipselect && read && (address == ADDR_EVENT) && !empty;
  assign flush   = wr && (address == ADDR_STATUS) && writedata[ST_FLUSH_BIT];
  assign push_ok = push && !flush && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp] <= ev;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wp <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      if (push_ok && !pop) begin
        count <= count + 7'd1;
      end else if (pop && !push_ok) begin
        count <= count - 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf  <= 1'b0;
      mask <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (push && !flush && full && !pop) begin
        ovf <= 1'b1;
      end else if (wr && (address == ADDR_STATUS) &&
                   writedata[ST_OVF_BIT]) begin
        ovf <= 1'b0;
      end
      if (wr && (address == ADDR_IRQMASK)) begin
        mask <= writedata[0];
      end
      irq <= mask && !empty;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (address)
      ADDR_STATE:   rdata[NUM_KEYS-1:0] = stable;
      ADDR_EVENT:   if (pop) rdata = ev_word(mem[rp]);
      ADDR_IRQMASK: rdata[0] = mask;
      ADDR_STATUS: begin
        rdata[ST_CNT_LSB +: 7] = count;
        rdata[ST_OVF_BIT]      = ovf;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rdata;
    end
  end

endmodule

// File: tb/tb_final_soc_key_ctrl.sv
// Self-checking bench for final_soc_key_ctrl with a scoreboard queue
// of expected EVENT words, popped as the CPU side reads them.
module tb_final_soc_key_ctrl;

  localparam int NK = 4;
  localparam int DB = 16;
  localparam int FD = 4;
  localparam int RP = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          read;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [NK-1:0] in_port;
  logic          irq;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  final_soc_key_ctrl #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB),
    .FIFO_DEPTH     (FD),
    .REPEAT_CYCLES  (RP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .read      (read),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    read = 1'b1;
    address = a;
    tick(1);
    chipselect = 1'b0;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] w);
    chipselect = 1'b1;
    write_n = 1'b0;
    address = a;
    writedata = w;
    tick(1);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic read_event(output logic [31:0] act,
                            output logic [31:0] exp);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = 32'h0;
    bus_read(2'd1, act);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset_n = 1'b0;
    tick(3);
    vectors++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: readdata %h irq %b want 0 0", readdata, irq);
    end
    reset_n = 1'b1;
    tick(2);
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      vectors++;
      if (d !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_reg%0d: got %h want 0", a, d);
      end
    end
  endtask

  task automatic test_bounce;
    logic [31:0] d, e;
    for (int i = 0; i < 5; i++) begin
      in_port[2] = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    in_port[2] = 1'b0;
    exp_q.push_back(32'h8000_0102);
    tick(30);
    bus_read(2'd0, d);
    vectors++;
    if (d !== 32'h4) begin
      miscompares++;
      $display("FAIL bounce_state: got %h want %h", d, 32'h4);
    end
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL bounce_count: got %h want %h", d, 32'h1);
    end
    read_event(d, e);
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL bounce_press: got %h want %h", d, e);
    end
    in_port[2] = 1'b1;
    exp_q.push_back(32'h8000_0002);
    tick(25);
    read_event(d, e);
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL bounce_release: got %h want %h", d, e);
    end
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    in_port[2] = 1'b0;
    tick(10);
    in_port[2] = 1'b1;
    tick(30);
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL glitch_count: got %h want 0", d);
    end
    bus_read(2'd0, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL glitch_state: got %h want 0", d);
    end
  endtask

  task automatic test_simultaneous;
    logic [31:0] d, e;
    in_port = 4'b0110;
    exp_q.push_back(32'h8000_0100);
    exp_q.push_back(32'h8000_0103);
    tick(25);
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'h2) begin
      miscompares++;
      $display("FAIL simul_count: got %h want 2", d);
    end
    in_port = 4'b1111;
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h8000_0003);
    for (int n = 0; n < 2; n++) begin
      read_event(d, e);
      vectors++;
      if (d !== e) begin
        miscompares++;
        $display("FAIL simul_press%0d: got %h want %h", n, d, e);
      end
    end
    tick(25);
    for (int n = 0; n < 3; n++) begin
      read_event(d, e);
      vectors++;
      if (d !== e) begin
        miscompares++;
        $display("FAIL simul_rel%0d: got %h want %h", n, d, e);
      end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] d, e;
    int n;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      in_port[k] = 1'b0;
      if (n < FD) exp_q.push_back(32'h8000_0100 | 32'(k));
      n++;
      tick(25);
      in_port[k] = 1'b1;
      if (n < FD) exp_q.push_back(32'h8000_0000 | 32'(k));
      n++;
      tick(25);
    end
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'h0001_0004) begin
      miscompares++;
      $display("FAIL ovf_status: got %h want %h", d, 32'h0001_0004);
    end
    bus_write(2'd3, 32'h0001_0000);
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'h4) begin
      miscompares++;
      $display("FAIL ovf_clear: got %h want 4", d);
    end
    for (int i = 0; i < FD; i++) begin
      read_event(d, e);
      vectors++;
      if (d !== e) begin
        miscompares++;
        $display("FAIL ovf_order%0d: got %h want %h", i, d, e);
      end
    end
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL ovf_drained: got %h want 0", d);
    end
  endtask

  task automatic test_flush;
    logic [31:0] d, e;
    in_port[3] = 1'b0;
    tick(25);
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL flush_pre: got %h want 1", d);
    end
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL flush_post: got %h want 0", d);
    end
    in_port[3] = 1'b1;
    exp_q.push_back(32'h8000_0003);
    tick(25);
    read_event(d, e);
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL flush_after: got %h want %h", d, e);
    end
  endtask

  task automatic test_irq;
    logic [31:0] d, e;
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, d);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL irq_mask: got %h want 1", d);
    end
    in_port[1] = 1'b0;
    exp_q.push_back(32'h8000_0101);
    tick(2 + DB + 1);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_early: got %b want 0", irq);
    end
    tick(1);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_rise: got %b want 1", irq);
    end
    read_event(d, e);
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL irq_pop: got %h want %h", d, e);
    end
    tick(1);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_fall: got %b want 0", irq);
    end
    read_event(d, e);
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL irq_empty_read: got %h want %h", d, e);
    end
    in_port[1] = 1'b1;
    exp_q.push_back(32'h8000_0001);
    tick(25);
    read_event(d, e);
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL irq_release: got %h want %h", d, e);
    end
    bus_write(2'd2, 32'h0);
  endtask

  task automatic test_repeat;
    logic [31:0] d, e;
    int sz;
    in_port[1] = 1'b0;
    exp_q.push_back(32'h8000_0101);
`ifdef FINAL_SOC_KEY_CTRL_AUTOREPEAT_EN
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h8000_0301);
`endif
    tick(2 + DB + 200);
    sz = exp_q.size();
    bus_read(2'd3, d);
    vectors++;
    if (d !== 32'(sz)) begin
      miscompares++;
      $display("FAIL rep_count: got %h want %h", d, 32'(sz));
    end
    for (int i = 0; i < sz; i++) begin
      read_event(d, e);
      vectors++;
      if (d !== e) begin
        miscompares++;
        $display("FAIL rep_event%0d: got %h want %h", i, d, e);
      end
    end
    in_port[1] = 1'b1;
    exp_q.push_back(32'h8000_0001);
    tick(25);
    read_event(d, e);
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL rep_release: got %h want %h", d, e);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    address = 2'd0;
    chipselect = 1'b0;
    read = 1'b0;
    write_n = 1'b1;
    writedata = 32'h0;
    in_port = 4'hF;
    test_reset();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_flush();
    test_irq();
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/final_soc_key_ctrl.md
# final_soc_key_ctrl

Debounced key-event controller for the SoC's push-button inputs. It samples the raw board keys, removes contact bounce, and turns each debounced press or release into an event word in a small FIFO. The CPU pops events over an Avalon-MM slave, and `irq` flags a non-empty queue. Game-control software gets one clean event per key action instead of polling a raw level register.

## Interface
- `NUM_KEYS`, 4, number of key inputs (1..8).
- `DEBOUNCE_CYCLES`, 500000, cycles a sample must stay stable before it is accepted (10 ms at 50 MHz); must be ≥ NUM_KEYS+2.
- `FIFO_DEPTH`, 8, event queue depth; power of two, 2..64.
- `REPEAT_CYCLES`, 12500000, autorepeat period (only used with autorepeat compiled in).
- `clk` in 1: system clock; single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `read` in 1: read strobe; sampled with chipselect.
- `write_n` in 1: active-low write strobe; sampled with chipselect.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data, read latency 1.
- `in_port` in NUM_KEYS: raw keys, active-low (0 = pressed), asynchronous to clk.
- `irq` out 1: registered interrupt, level-sensitive.

## Operation
- Register map:
  - addr 0 STATE (RO): debounced levels in [NUM_KEYS-1:0], 1 = pressed.
  - addr 1 EVENT (RO, pop on read): bit31 valid, bit9 repeat, bit8 press(1)/release(0), [2:0] key index.
  - addr 2 IRQMASK (RW): bit0 enables irq.
  - addr 3 STATUS: [6:0] FIFO count, bit16 overflow (sticky). Writing 1 to bit16 clears overflow; writing 1 to bit0 flushes the FIFO.
- Input path per key:
  - Invert the raw key, then pass it through a 2-flop synchronizer.
  - If the sample differs from the stable state, the debounce counter increments. Otherwise the counter clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable state toggles, the counter clears, and the key's pending flag is set with kind = new state.
- Event arbiter: fixed priority, lowest key index first. Pushes at most one pending event per cycle and clears that key's pending flag.
- FIFO behaviour:
  - Full and no pop: the pushed event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
- EVENT read:
  - The pop occurs on the cycle where chipselect&read&address==1 and the FIFO is non-empty. readdata returns that head entry with valid=1.
  - Empty: readdata returns 0 and nothing changes.
  - Reads of other addresses have no side effects.
- Flush write while a push is pending in the same cycle: the flush wins and the push is discarded.
- irq = IRQMASK[0] & (count != 0), registered.

## Timing
- Reset values: readdata 0, irq 0, stable states 0 (released), counters 0, pending 0, FIFO empty, IRQMASK 0, overflow 0.
- Reset mid-operation clears all in-flight events immediately (asynchronously).
- Latency from a raw edge that stays clean to the event being visible in the FIFO: 2 (sync) + DEBOUNCE_CYCLES + 1 (arbiter push) cycles. Worst case under contention adds up to NUM_KEYS-1 cycles.
- irq asserts 1 cycle after the FIFO becomes non-empty. It deasserts 1 cycle after the pop that empties it.
- readdata is registered every clock from the address mux, so data appears on the cycle after the read strobe.
- A glitch shorter than DEBOUNCE_CYCLES produces no event.

## Configuration
- Macro: `FINAL_SOC_KEY_CTRL_AUTOREPEAT_EN`.
- Defined:
  - A per-key repeat counter runs while the key's stable state = pressed.
  - After REPEAT_CYCLES, and every REPEAT_CYCLES after that, the key's pending flag is set with press=1 and repeat=1.
  - A release clears the repeat counter.
- Undefined: no repeat logic is built; bit9 always reads 0 and REPEAT_CYCLES is ignored.

## Structure
- Package `final_soc_key_pkg` holds:
  - register address constants;
  - EVENT bit positions (valid, repeat, press, index);
  - a packed event typedef {repeat, press, idx};
  - the STATUS bit constants.
- Sub-module `final_soc_key_debounce` (synchronizer + counter + stable state + pending kind), one instance per key via generate. The FIFO and arbiter stay in the top level.

## Test plan
- Bench settings: DEBOUNCE_CYCLES=16, FIFO_DEPTH=4, REPEAT_CYCLES=64.
- Key 2 held low 30 cycles, after 5 cycles of 1/0 bounce → exactly one event 0x8000_0102. STATE reads 0x4.
- Key 2 pulse low for 10 cycles → no event; count stays 0; STATE stays 0.
- Keys 0 and 3 pressed on the same cycle → events popped in order 0x8000_0100, then 0x8000_0103.
- Six press/release events with no reads → count 4, overflow=1. The first four events are retained in order. Writing 0x1_0000 to addr 3 clears overflow.
- IRQMASK=1, one press → irq high 1 cycle after push. Pop → irq low next cycle. Further EVENT read → readdata 0.
- Autorepeat build, key 1 held 200 cycles after debounce → press event, then 3 events 0x8000_0301 at 64-cycle spacing. Non-autorepeat build → press event only.
